// File: rtl/display_view_sequencer_pkg.sv
// Shared view and edit-select encodings for the display view path.
// The config FSM imports this package as well, so these codes must stay stable.
package display_view_sequencer_pkg;

   typedef enum logic [1:0] {
      S_TIME  = 2'b01,
      S_DATE  = 2'b10,
      S_TIMER = 2'b11
   } view_state_t;

   localparam logic [1:0] VIEW_TIME  = 2'b01;
   localparam logic [1:0] VIEW_DATE  = 2'b10;
   localparam logic [1:0] VIEW_TIMER = 2'b11;

   localparam logic [1:0] EDIT_HOLD  = 2'b00;
   localparam logic [1:0] EDIT_TIME  = 2'b01;
   localparam logic [1:0] EDIT_DATE  = 2'b10;
   localparam logic [1:0] EDIT_TIMER = 2'b11;

   // Rotation order TIME -> DATE -> TIMER -> TIME; TIMER is skipped when disabled.
   function automatic view_state_t next_view(input view_state_t cur, input logic timer_en);
      case (cur)
         S_TIME:  next_view = S_DATE;
         S_DATE:  next_view = timer_en ? S_TIMER : S_TIME;
         default: next_view = S_TIME;
      endcase
   endfunction

endpackage

// File: rtl/display_view_sequencer_dwell_timer.sv
// Per-view dwell counter: counts enabled cycles and flags the last cycle of the dwell.
// The limit is chosen by the caller, so one counter serves every view.
module dwell_timer #(
   parameter int CNT_W = 27
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             expire
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expire = (count == limit - CNT_W'(1));

endmodule

// File: rtl/display_view_sequencer.sv
// One-hot view select for the display output selector: auto-rotation with per-view
// dwell, manual next button, and an edit-mode override that pins the edited view.
module display_view_sequencer
   import display_view_sequencer_pkg::*;
#(
   parameter int CNT_W       = 27,
   parameter int DWELL_TIME  = 100_000_000,
   parameter int DWELL_DATE  = 50_000_000,
   parameter int DWELL_TIMER = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       auto_en,
   input  logic       btn_next,
   input  logic       timer_en,
   input  logic       edit_mode,
   input  logic [1:0] edit_sel,
   output logic       f1,
   output logic       f2,
   output logic       f3,
   output logic [1:0] view_id,
   output logic       view_chg
);

   localparam logic [CNT_W-1:0] LIM_TIME  = CNT_W'(DWELL_TIME);
   localparam logic [CNT_W-1:0] LIM_DATE  = CNT_W'(DWELL_DATE);
   localparam logic [CNT_W-1:0] LIM_TIMER = CNT_W'(DWELL_TIMER);

   view_state_t      state;
   view_state_t      state_nxt;
   logic             dwell_clr;
   logic             dwell_en;
   logic             dwell_expire;
   logic [CNT_W-1:0] dwell_limit;

   always_comb begin
      case (state)
         S_DATE:  dwell_limit = LIM_DATE;
         S_TIMER: dwell_limit = LIM_TIMER;
         default: dwell_limit = LIM_TIME;
      endcase
   end

   dwell_timer #(
      .CNT_W (CNT_W)
   ) u_dwell (
      .clk    (clk),
      .reset  (reset),
      .clr    (dwell_clr),
      .en     (dwell_en),
      .limit  (dwell_limit),
      .expire (dwell_expire)
   );

   // Priority: edit override, then timer view withdrawn, then button, then dwell expiry.
   always_comb begin
      state_nxt = state;
      dwell_clr = 1'b0;
      dwell_en  = auto_en & ~edit_mode;
      if (edit_mode) begin
         dwell_clr = 1'b1;
         case (edit_sel)
            EDIT_TIME:  state_nxt = S_TIME;
            EDIT_DATE:  state_nxt = S_DATE;
            EDIT_TIMER: state_nxt = S_TIMER;
            default:    state_nxt = state;
         endcase
      end else if (state == S_TIMER && !timer_en) begin
         state_nxt = S_TIME;
         dwell_clr = 1'b1;
      end else if (btn_next) begin
         state_nxt = next_view(state, timer_en);
         dwell_clr = 1'b1;
      end else if (auto_en && dwell_expire) begin
         state_nxt = next_view(state, timer_en);
         dwell_clr = 1'b1;
      end
   end

   // Selects are registered from the next state so they change on the deciding edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_TIME;
         f1       <= 1'b1;
         f2       <= 1'b0;
         f3       <= 1'b0;
         view_chg <= 1'b0;
      end else begin
         state    <= state_nxt;
         f1       <= (state_nxt == S_TIME);
         f2       <= (state_nxt == S_DATE);
         f3       <= (state_nxt == S_TIMER);
         view_chg <= (state_nxt != state);
      end
   end

   assign view_id = state;

endmodule

// File: tb/tb_display_view_sequencer.sv
// Self-checking bench for display_view_sequencer: a cycle model of the view rules
// checked every cycle, plus hand-computed expectations at key cycles.
module tb_display_view_sequencer;

   localparam int D_TIME  = 4;
   localparam int D_DATE  = 3;
   localparam int D_TIMER = 2;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       auto_en   = 1'b0;
   logic       btn_next  = 1'b0;
   logic       timer_en  = 1'b0;
   logic       edit_mode = 1'b0;
   logic [1:0] edit_sel  = 2'b00;
   logic       f1;
   logic       f2;
   logic       f3;
   logic [1:0] view_id;
   logic       view_chg;

   int          checks      = 0;
   int          failures    = 0;
   int          exp_view    = 1;
   int          exp_elapsed = 0;
   bit          exp_chg     = 1'b0;
   bit          model_valid = 1'b0;
   int          dwell_of [4] = '{0, D_TIME, D_DATE, D_TIMER};
   logic [31:0] chg_mask;
   int          f3_seen;

   always #5 clk = ~clk;

   display_view_sequencer #(
      .CNT_W       (4),
      .DWELL_TIME  (D_TIME),
      .DWELL_DATE  (D_DATE),
      .DWELL_TIMER (D_TIMER)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .auto_en   (auto_en),
      .btn_next  (btn_next),
      .timer_en  (timer_en),
      .edit_mode (edit_mode),
      .edit_sel  (edit_sel),
      .f1        (f1),
      .f2        (f2),
      .f3        (f3),
      .view_id   (view_id),
      .view_chg  (view_chg)
   );

   function automatic int successor(input int v, input logic ten);
      if (v == 1) return 2;
      if (v == 2) return ten ? 3 : 1;
      return 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic expectView(input string name, input int view, input logic chg);
      checkOutput({name, "_view_id"}, 32'(view_id), 32'(view));
      checkOutput({name, "_view_chg"}, 32'(view_chg), 32'(chg));
   endtask

   task automatic applyStimulus(input logic a, input logic b, input logic t,
                                input logic e, input logic [1:0] s);
      auto_en   = a;
      btn_next  = b;
      timer_en  = t;
      edit_mode = e;
      edit_sel  = s;
      @(negedge clk);
   endtask

   task automatic resetDut();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
      reset = 1'b0;
   endtask

   // Model: view number 1..3 and how many cycles it has been shown so far.
   always @(posedge clk) begin : model
      int prev;
      prev = exp_view;
      if (reset) begin
         exp_view    = 1;
         exp_elapsed = 0;
      end else if (edit_mode) begin
         exp_elapsed = 0;
         if (edit_sel != 2'b00) exp_view = int'(edit_sel);
      end else if (exp_view == 3 && !timer_en) begin
         exp_view    = 1;
         exp_elapsed = 0;
      end else if (btn_next) begin
         exp_view    = successor(exp_view, timer_en);
         exp_elapsed = 0;
      end else if (auto_en) begin
         exp_elapsed++;
         if (exp_elapsed >= dwell_of[exp_view]) begin
            exp_view    = successor(exp_view, timer_en);
            exp_elapsed = 0;
         end
      end
      exp_chg     = !reset && (exp_view != prev);
      model_valid = 1'b1;
   end

   always @(negedge clk) begin : compare
      logic [2:0] exp_f;
      if (model_valid) begin
         exp_f = 3'b100 >> (exp_view - 1);
         checkOutput("model_f", 32'({f1, f2, f3}), 32'(exp_f));
         checkOutput("model_view_id", 32'(view_id), 32'(exp_view));
         checkOutput("model_view_chg", 32'(view_chg), 32'(exp_chg));
      end
   end

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
      resetDut();
      expectView("reset", 1, 1'b0);
      checkOutput("reset_f", 32'({f1, f2, f3}), 32'(3'b100));

      chg_mask = '0;
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
         if (view_chg) chg_mask[c] = 1'b1;
         if (c == 4) expectView("rot_c4", 2, 1'b1);
         if (c == 9) expectView("rot_c9", 1, 1'b1);
      end
      checkOutput("rot_chg_cycles", chg_mask,
                  32'((1 << 4) | (1 << 7) | (1 << 9) | (1 << 13) | (1 << 16) | (1 << 18)));

      f3_seen = 0;
      for (int c = 0; c < 14; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
         if (f3) f3_seen++;
      end
      checkOutput("no_timer_f3", 32'(f3_seen), 32'd0);

      resetDut();
      for (int c = 0; c < 11; c++) begin
         applyStimulus(1'b0, (c == 2 || c == 5 || c == 8), 1'b1, 1'b0, 2'b00);
         if (c + 1 == 3)  expectView("btn_c3", 2, 1'b1);
         if (c + 1 == 6)  expectView("btn_c6", 3, 1'b1);
         if (c + 1 == 9)  expectView("btn_c9", 1, 1'b1);
         if (c + 1 == 11) expectView("btn_c11", 1, 1'b0);
      end

      resetDut();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, (c == 3), 1'b1, 1'b0, 2'b00);
         if (c + 1 == 4) expectView("coinc_c4", 2, 1'b1);
         if (c + 1 == 6) expectView("coinc_c6", 2, 1'b0);
         if (c + 1 == 7) expectView("coinc_c7", 3, 1'b1);
      end

      resetDut();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
      expectView("edit_force_date", 2, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, (i % 3 == 0), 1'b1, 1'b1, 2'b10);
      expectView("edit_stay_date", 2, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
      expectView("edit_hold", 2, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
      expectView("edit_timer_disabled", 3, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
      expectView("edit_timer_same", 3, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
      expectView("edit_exit_1", 3, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
      expectView("edit_exit_2", 1, 1'b1);

      resetDut();
      for (int c = 0; c < 7; c++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
      expectView("drop_in_timer", 3, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      expectView("drop_to_time", 1, 1'b1);
      for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      expectView("drop_then_date", 2, 1'b1);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
      reset = 1'b0;
      expectView("reset_mid", 1, 1'b0);
      checkOutput("reset_mid_f", 32'({f1, f2, f3}), 32'(3'b100));
      for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
      expectView("reset_mid_dwell", 1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
      expectView("reset_mid_next", 2, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
